// File: rtl/uart_cmd_engine_if.sv
// uart_cmd_engine_if: bundles the UART byte streams, the register-file
// port and the status pulses of uart_cmd_engine.
//
// Handshake semantics:
//   rx_valid  - one-cycle strobe, no back-pressure; rx_data is valid only
//               in that cycle.
//   tx_valid/tx_ready - a byte moves on every clock edge where both are high;
//               once tx_valid is raised, it and tx_data hold until that edge.
//   reg_we/reg_re - one-cycle strobes; rd_data is valid exactly one cycle
//               after reg_re.
interface uart_cmd_engine_if #(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 1
);
  localparam int DW = 8 * DATA_BYTES;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              reg_we;
  logic              reg_re;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]     w_data;
  logic [DW-1:0]     rd_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              err_timeout;
  logic              err_overrun;
  logic [2:0]        dbg_state;

  // Engine side.
  modport master (
    input  rx_valid, rx_data, rd_data, tx_ready,
    output reg_we, reg_re, w_addr, r_addr, w_data, tx_valid, tx_data,
           busy, err_timeout, err_overrun, dbg_state
  );

  // Environment side: UART rx/tx and register file.
  modport slave (
    output rx_valid, rx_data, rd_data, tx_ready,
    input  reg_we, reg_re, w_addr, r_addr, w_data, tx_valid, tx_data,
           busy, err_timeout, err_overrun, dbg_state
  );
endinterface

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: decodes a UART byte stream (CMD, ADDR, data) into burst
// register writes/reads with address auto-increment, streams read words back
// LSB first and aborts stalled frames on an inter-byte timeout.
// Optional feature macro: UART_CMD_ENGINE_ACK_EN adds an ACK state that sends
// 0xA5 after a write burst and 0xEE after a timeout abort.
module uart_cmd_engine #(
  parameter int ADDR_W      = 6,
  parameter int DATA_BYTES  = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  uart_cmd_engine_if.master  bus
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [1:0]    LAST_B   = 2'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RD_ISSUE, S_RD_WAIT, S_RD_SEND
`ifdef UART_CMD_ENGINE_ACK_EN
    , S_ACK
`endif
  } state_t;

`ifdef UART_CMD_ENGINE_ACK_EN
  localparam state_t S_END = S_ACK;
`else
  localparam state_t S_END = S_IDLE;
`endif

  state_t            state, next;
  logic              wr_cmd;      // latched CMD[7]
  logic [3:0]        cnt;         // words remaining after the current one
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bidx;        // byte index within the current word
  logic [DW-1:0]     wbuf;        // write word under assembly
  logic [DW-1:0]     shreg;       // read word being shifted out
  logic [TW-1:0]     tmo;         // cycles since the last received byte
  logic              rx_phase, drop_phase, tmo_hit;
  logic              we_c, re_c, txv_c;
  logic [7:0]        txd_c;
  logic              err_to_q, err_ov_q;
`ifdef UART_CMD_ENGINE_ACK_EN
  logic [7:0]        ack_code;
`endif

  // Bytes are consumed only while a frame is being received.
  assign rx_phase   = (state == S_ADDR) || (state == S_WDATA);
  assign drop_phase = (state != S_IDLE) && !rx_phase;
  // A byte arriving in the final cycle still rescues the frame.
  assign tmo_hit    = (TIMEOUT_CYC != 0) && rx_phase && !bus.rx_valid && (tmo == TMO_LAST);

  assign bus.reg_we      = we_c;
  assign bus.reg_re      = re_c;
  assign bus.w_addr      = addr;
  assign bus.r_addr      = addr;
  assign bus.w_data      = wbuf;
  assign bus.tx_valid    = txv_c;
  assign bus.tx_data     = txd_c;
  assign bus.busy        = (state != S_IDLE);
  assign bus.err_timeout = err_to_q;
  assign bus.err_overrun = err_ov_q;
  assign bus.dbg_state   = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    next  = state;
    we_c  = 1'b0;
    re_c  = 1'b0;
    txv_c = 1'b0;
    txd_c = 8'h00;
    case (state)
      S_IDLE:     if (bus.rx_valid) next = S_ADDR;
      S_ADDR: begin
        if (tmo_hit)           next = S_END;
        else if (bus.rx_valid) next = wr_cmd ? S_WDATA : S_RD_ISSUE;
      end
      S_WDATA: begin
        if (tmo_hit)                             next = S_END;
        else if (bus.rx_valid && bidx == LAST_B) next = S_WRITE;
      end
      S_WRITE: begin
        we_c = 1'b1;
        next = (cnt != 4'd0) ? S_WDATA : S_END;
      end
      S_RD_ISSUE: begin
        re_c = 1'b1;
        next = S_RD_WAIT;
      end
      S_RD_WAIT:  next = S_RD_SEND;
      S_RD_SEND: begin
        txv_c = 1'b1;
        txd_c = shreg[7:0];
        if (bus.tx_ready && bidx == LAST_B) next = (cnt != 4'd0) ? S_RD_ISSUE : S_IDLE;
      end
`ifdef UART_CMD_ENGINE_ACK_EN
      S_ACK: begin
        txv_c = 1'b1;
        txd_c = ack_code;
        if (bus.tx_ready) next = S_IDLE;
      end
`endif
      default:    next = S_IDLE;
    endcase
  end

  // Frame datapath: command latch, address/word counters, byte assembly,
  // read shifter, idle counter and error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cmd   <= 1'b0;
      cnt      <= 4'd0;
      addr     <= '0;
      bidx     <= 2'd0;
      wbuf     <= '0;
      shreg    <= '0;
      tmo      <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
`ifdef UART_CMD_ENGINE_ACK_EN
      ack_code <= 8'h00;
`endif
    end else begin
      err_to_q <= tmo_hit;
      err_ov_q <= bus.rx_valid && drop_phase;
      if (bus.rx_valid || !rx_phase || tmo_hit) tmo <= '0;
      else                                      tmo <= tmo + 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            wr_cmd <= bus.rx_data[7];
            cnt    <= bus.rx_data[3:0];
          end
        end
        S_ADDR, S_WDATA: begin
          if (tmo_hit) begin
            wbuf <= '0;
`ifdef UART_CMD_ENGINE_ACK_EN
            ack_code <= 8'hEE;
`endif
          end else if (bus.rx_valid) begin
            if (state == S_ADDR) begin
              addr <= bus.rx_data[ADDR_W-1:0];
              bidx <= 2'd0;
            end else begin
              for (int b = 0; b < DATA_BYTES; b++)
                if (bidx == 2'(b)) wbuf[8*b +: 8] <= bus.rx_data;
              bidx <= bidx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          bidx <= 2'd0;
          if (cnt != 4'd0) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 4'd1;
          end
`ifdef UART_CMD_ENGINE_ACK_EN
          else ack_code <= 8'hA5;
`endif
        end
        S_RD_WAIT: begin
          shreg <= bus.rd_data;
          bidx  <= 2'd0;
        end
        S_RD_SEND: begin
          if (bus.tx_ready) begin
            if (bidx == LAST_B) begin
              if (cnt != 4'd0) begin
                addr <= addr + 1'b1;
                cnt  <= cnt - 4'd1;
              end
            end else begin
              shreg <= shreg >> 8;
              bidx  <= bidx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb_uart_cmd_engine: table-driven frames with a scoreboard of expected
// writes, read addresses and tx bytes, plus hand-written sequences for read
// latency, back-pressure, overrun, timeout and mid-frame reset.
module tb_uart_cmd_engine;
  localparam int ADDR_W      = 6;
  localparam int DATA_BYTES  = 2;
  localparam int TIMEOUT_CYC = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_engine_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) bus ();

  uart_cmd_engine #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic            wr;
    logic [5:0]      addr;
    logic [1:0]      nw;
    logic [1:0][15:0] wd;   // data sent (writes)
    logic [1:0][5:0]  ea;   // expected address per word
    logic [1:0][15:0] ew;   // expected word per word
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_wr_q[$];
  logic [5:0]  exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] mem [64];
  int          ready_mode = 0;   // 0 low, 1 high, 2 random
  logic        hold_pend  = 1'b0;
  logic [7:0]  hold_data  = 8'h00;
  vec_t        tbl [6];

  // Register-file model: write on reg_we, read data one cycle after reg_re.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      bus.rd_data <= 16'h0000;
    end else begin
      if (bus.reg_we) mem[bus.w_addr] <= bus.w_data;
      bus.rd_data <= bus.reg_re ? mem[bus.r_addr] : 16'h0000;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, required no event", nm, act);
  endtask

  // Scoreboard sampling at the falling edge.
  task automatic sample();
    logic [21:0] ew;
    logic [5:0]  ea;
    logic [7:0]  eb;
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.reg_we && bus.reg_re) unexpected("we_re_overlap", 32'(bus.w_addr));
      if (bus.reg_we) begin
        if (exp_wr_q.size() == 0) unexpected("unexpected_write", 32'({bus.w_addr, bus.w_data}));
        else begin
          ew = exp_wr_q.pop_front();
          chk("write_addr_data", 32'({bus.w_addr, bus.w_data}), 32'(ew));
        end
      end
      if (bus.reg_re) begin
        if (exp_rd_q.size() == 0) unexpected("unexpected_read", 32'(bus.r_addr));
        else begin
          ea = exp_rd_q.pop_front();
          chk("read_addr", 32'(bus.r_addr), 32'(ea));
        end
      end
      if (hold_pend) begin
        chk("tx_hold_valid", 32'(bus.tx_valid), 1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(hold_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx_q.size() == 0) unexpected("unexpected_tx", 32'(bus.tx_data));
        else begin
          eb = exp_tx_q.pop_front();
          chk("tx_byte", 32'(bus.tx_data), 32'(eb));
        end
      end
      hold_pend = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       bus.tx_ready = 1'b0;
      1:       bus.tx_ready = 1'b1;
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    drive_ready();
  endtask

  // One clock: scoreboard at the falling edge, new inputs 1 ns after the rising edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap(input int lo);
    int n;
    n = $urandom_range(lo, 3);
    repeat (n) step();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((bus.busy || exp_tx_q.size() != 0 || exp_wr_q.size() != 0 ||
            exp_rd_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    chk(nm, 32'(n < 400), 1);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_reg_we"},      32'(bus.reg_we), 0);
    chk({p, "_reg_re"},      32'(bus.reg_re), 0);
    chk({p, "_w_addr"},      32'(bus.w_addr), 0);
    chk({p, "_r_addr"},      32'(bus.r_addr), 0);
    chk({p, "_w_data"},      32'(bus.w_data), 0);
    chk({p, "_tx_valid"},    32'(bus.tx_valid), 0);
    chk({p, "_tx_data"},     32'(bus.tx_data), 0);
    chk({p, "_busy"},        32'(bus.busy), 0);
    chk({p, "_err_timeout"}, 32'(bus.err_timeout), 0);
    chk({p, "_err_overrun"}, 32'(bus.err_overrun), 0);
  endtask

  function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [1:0] n,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.wr = wr; v.addr = a; v.nw = n;
    v.wd = {d1, d0}; v.ea = {a1, a0}; v.ew = {e1, e0};
    return v;
  endfunction

  // Pushes the frame's expected results, then sends it with random gaps.
  // CMD[6:4] and ADDR[7:6] carry junk that must be ignored.
  task automatic run_frame(input vec_t v);
    int n;
    n = int'(v.nw);
    for (int i = 0; i < n; i++) begin
      if (v.wr) exp_wr_q.push_back({v.ea[i], v.ew[i]});
      else begin
        exp_rd_q.push_back(v.ea[i]);
        exp_tx_q.push_back(v.ew[i][7:0]);
        exp_tx_q.push_back(v.ew[i][15:8]);
      end
    end
`ifdef UART_CMD_ENGINE_ACK_EN
    if (v.wr) exp_tx_q.push_back(8'hA5);
`endif
    send_byte({v.wr, 3'b101, 4'(n - 1)});
    gap(0);
    send_byte({2'b10, v.addr});
    if (v.wr) begin
      for (int i = 0; i < n; i++) begin
        gap(0);
        send_byte(v.wd[i][7:0]);
        gap(0);
        send_byte(v.wd[i][15:8]);
        gap(1);
      end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    tbl[0] = mk(1'b1, 6'h3F, 2'd2, 16'h1234, 16'h5678, 6'h3F, 6'h00, 16'h1234, 16'h5678);
    tbl[1] = mk(1'b0, 6'h3F, 2'd2, 16'h0000, 16'h0000, 6'h3F, 6'h00, 16'h1234, 16'h5678);
    tbl[2] = mk(1'b1, 6'h05, 2'd1, 16'hBEEF, 16'h0000, 6'h05, 6'h00, 16'hBEEF, 16'h0000);
    tbl[3] = mk(1'b1, 6'h10, 2'd2, 16'hA1B2, 16'hC3D4, 6'h10, 6'h11, 16'hA1B2, 16'hC3D4);
    tbl[4] = mk(1'b0, 6'h11, 2'd1, 16'h0000, 16'h0000, 6'h11, 6'h00, 16'hC3D4, 16'h0000);
    tbl[5] = mk(1'b0, 6'h10, 2'd2, 16'h0000, 16'h0000, 6'h10, 6'h11, 16'hA1B2, 16'hC3D4);

    // Reset values.
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;
    step();

    // Table-driven bursts with random tx back-pressure.
    set_ready(2);
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i]);
      wait_done($sformatf("frame%0d_done", i));
    end

    // Single read: latency, back-pressure and an overrun byte during RD_SEND.
    set_ready(0);
    exp_rd_q.push_back(6'h05);
    exp_tx_q.push_back(8'hEF);
    exp_tx_q.push_back(8'hBE);
    send_byte(8'h00);
    send_byte(8'h05);
    chk("rd_reg_re_n1", 32'(bus.reg_re), 1);
    chk("rd_r_addr_n1", 32'(bus.r_addr), 5);
    step();
    chk("rd_reg_re_n2", 32'(bus.reg_re), 0);
    chk("rd_tx_valid_n2", 32'(bus.tx_valid), 0);
    step();
    chk("rd_tx_valid_n3", 32'(bus.tx_valid), 1);
    chk("rd_tx_data_n3", 32'(bus.tx_data), 32'hEF);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
      end
      step();
      bus.rx_valid = 1'b0;
      if (k == 3) chk("overrun_pulse", 32'(bus.err_overrun), 1);
      if (k == 4) chk("overrun_single", 32'(bus.err_overrun), 0);
      chk("bp_tx_data", 32'(bus.tx_data), 32'hEF);
      chk("bp_tx_valid", 32'(bus.tx_valid), 1);
    end
    set_ready(1);
    step();
    chk("rd_byte1_data", 32'(bus.tx_data), 32'hBE);
    chk("rd_byte1_valid", 32'(bus.tx_valid), 1);
    step();
    chk("rd_end_tx_valid", 32'(bus.tx_valid), 0);
    chk("rd_end_busy", 32'(bus.busy), 0);
    wait_done("read_single_done");

    // Timeout: write frame stalls after its first data byte.
    set_ready(0);
`ifdef UART_CMD_ENGINE_ACK_EN
    exp_tx_q.push_back(8'hEE);
`endif
    send_byte(8'h80);
    send_byte(8'h02);
    send_byte(8'h11);
    begin
      logic early;
      early = 1'b0;
      for (int i = 1; i <= 50; i++) begin
        step();
        if (i < 50 && bus.err_timeout) early = 1'b1;
        if (i == 49) chk("tmo_busy_before", 32'(bus.busy), 1);
      end
      chk("tmo_not_early", 32'(early), 0);
    end
    chk("tmo_pulse", 32'(bus.err_timeout), 1);
`ifdef UART_CMD_ENGINE_ACK_EN
    chk("tmo_busy_ack", 32'(bus.busy), 1);
    chk("tmo_ack_byte", 32'(bus.tx_data), 32'hEE);
`else
    chk("tmo_idle", 32'(bus.busy), 0);
`endif
    step();
    chk("tmo_single", 32'(bus.err_timeout), 0);
    set_ready(2);
    wait_done("timeout_done");

    // Reset mid-frame with a partial word in flight, then a normal frame.
    send_byte(8'h81);
    send_byte(8'h20);
    send_byte(8'h33);
    chk("midrst_busy_before", 32'(bus.busy), 1);
    reset = 1'b0;
    step();
    chk_zero("midrst");
    reset = 1'b1;
    step();
    run_frame(mk(1'b1, 6'h20, 2'd1, 16'h4455, 16'h0000, 6'h20, 6'h00, 16'h4455, 16'h0000));
    wait_done("post_reset_write_done");
    run_frame(mk(1'b0, 6'h20, 2'd1, 16'h0000, 16'h0000, 6'h20, 6'h00, 16'h4455, 16'h0000));
    wait_done("post_reset_read_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
